// File: rtl/i2c_pkg.sv
// Shared types for the I2C transmit-path arbiter: FSM states, width defaults, client index.
package i2c_pkg;

    localparam int ADDR_W_DFLT = 7;
    localparam int LEN_W_DFLT  = 6;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        PRIME0,
        PRIME1,
        RUN,
        FINISH
    } state_t;

    typedef logic client_idx_t;

    function automatic logic [1:0] onehot2(input client_idx_t idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/i2c_tx_arbiter_rr_arb2.sv
// Two-way round-robin pick; the pointer names the client that wins a tie.
module rr_arb2
    import i2c_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       adv,
    input  logic       last,
    output logic [1:0] win
);

    client_idx_t rr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (adv) begin
            rr_ptr <= ~last;
        end
    end

    always_comb begin
        win = req;
        if (req == 2'b11) begin
            win = onehot2(rr_ptr);
        end
    end

endmodule

// File: rtl/i2c_tx_arbiter.sv
// Grants one of two clients a burst and keeps the TX controller's two byte buffers fed.
//   state  | meaning
//   IDLE   | waiting for a request; latches winner's address and length
//   GRANT  | zero-length bursts complete here, otherwise start priming
//   PRIME0 | fetching first byte into buffer 0
//   PRIME1 | fetching second byte into buffer 1
//   RUN    | tx_start held; refilling drained buffers until tx_done/tx_nack
//   FINISH | grant and tx_start low; pointer moves to the other client
module i2c_tx_arbiter
    import i2c_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int LEN_W  = LEN_W_DFLT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [LEN_W-1:0]  req_len0,
    input  logic [LEN_W-1:0]  req_len1,
    output logic [1:0]        grant,
    output logic              byte_req,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic [1:0]        done,
    output logic [1:0]        err,
    output logic              tx_start,
    output logic [ADDR_W-1:0] tx_addr,
    output logic [LEN_W-1:0]  tx_len,
    output logic [7:0]        buf_data,
    output logic              load_buf0,
    output logic              load_buf1,
    input  logic              buf_empty0,
    input  logic              buf_empty1,
    input  logic              tx_done,
    input  logic              tx_nack
);

    state_t           state;
    client_idx_t      cur;
    logic [LEN_W-1:0] fetched;
    logic             fetch_busy;
    logic             fetch_tgt;
    logic [1:0]       pend;
    logic [1:0]       pend_nx;
    logic [1:0]       win;
    logic             rr_adv;
    logic             accept;
    logic             more;

    assign more   = fetched < tx_len;
    assign accept = fetch_busy && byte_valid;
    assign rr_adv = (state == FINISH) || ((state == GRANT) && (tx_len == '0));

    // Drain pulses only count while bytes remain to be fetched.
    always_comb begin
        pend_nx = pend | ({buf_empty1, buf_empty0} & {2{more}});
    end

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .adv   (rr_adv),
        .last  (cur),
        .win   (win)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cur        <= 1'b0;
            fetched    <= '0;
            fetch_busy <= 1'b0;
            fetch_tgt  <= 1'b0;
            pend       <= 2'b00;
            grant      <= 2'b00;
            byte_req   <= 1'b0;
            done       <= 2'b00;
            err        <= 2'b00;
            tx_start   <= 1'b0;
            tx_addr    <= '0;
            tx_len     <= '0;
            buf_data   <= 8'h00;
            load_buf0  <= 1'b0;
            load_buf1  <= 1'b0;
        end else begin
            byte_req  <= 1'b0;
            load_buf0 <= 1'b0;
            load_buf1 <= 1'b0;
            done      <= 2'b00;
            err       <= 2'b00;
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant   <= win;
                        cur     <= win[1];
                        tx_addr <= win[1] ? req_addr1 : req_addr0;
                        tx_len  <= win[1] ? req_len1 : req_len0;
                        fetched <= '0;
                        pend    <= 2'b00;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (tx_len == '0) begin
                        done  <= onehot2(cur);
                        grant <= 2'b00;
                        state <= IDLE;
                    end else begin
                        byte_req   <= 1'b1;
                        fetch_busy <= 1'b1;
                        fetch_tgt  <= 1'b0;
                        state      <= PRIME0;
                    end
                end
                PRIME0: begin
                    if (accept) begin
                        buf_data  <= byte_in;
                        load_buf0 <= 1'b1;
                        fetched   <= fetched + 1'b1;
                        if (tx_len == LEN_W'(1)) begin
                            fetch_busy <= 1'b0;
                            state      <= RUN;
                        end else begin
                            byte_req  <= 1'b1;
                            fetch_tgt <= 1'b1;
                            state     <= PRIME1;
                        end
                    end
                end
                PRIME1: begin
                    if (accept) begin
                        buf_data   <= byte_in;
                        load_buf1  <= 1'b1;
                        fetched    <= fetched + 1'b1;
                        fetch_busy <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    tx_start <= 1'b1;
                    if (tx_nack || tx_done) begin
                        if (tx_nack) begin
                            err <= onehot2(cur);
                        end else begin
                            done <= onehot2(cur);
                        end
                        fetch_busy <= 1'b0;
                        pend       <= 2'b00;
                        grant      <= 2'b00;
                        tx_start   <= 1'b0;
                        state      <= FINISH;
                    end else if (accept) begin
                        buf_data   <= byte_in;
                        load_buf0  <= ~fetch_tgt;
                        load_buf1  <= fetch_tgt;
                        fetched    <= fetched + 1'b1;
                        fetch_busy <= 1'b0;
                        pend       <= pend_nx & ~onehot2(fetch_tgt);
                    end else if (!fetch_busy && (pend_nx != 2'b00) && more) begin
                        // Buffer 0 is refilled first when both are pending.
                        byte_req   <= 1'b1;
                        fetch_busy <= 1'b1;
                        fetch_tgt  <= ~pend_nx[0];
                        pend       <= pend_nx;
                    end else begin
                        pend <= more ? pend_nx : 2'b00;
                    end
                end
                FINISH: begin
                    tx_start <= 1'b0;
                    grant    <= 2'b00;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_tx_arbiter.sv
// Directed bench for i2c_tx_arbiter: priming, refills, round-robin, zero length, NACK abort, async reset.
module tb_i2c_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic [6:0] req_addr0 = 7'h00;
    logic [6:0] req_addr1 = 7'h00;
    logic [5:0] req_len0 = 6'd0;
    logic [5:0] req_len1 = 6'd0;
    logic [1:0] grant;
    logic       byte_req;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic [1:0] done;
    logic [1:0] err;
    logic       tx_start;
    logic [6:0] tx_addr;
    logic [5:0] tx_len;
    logic [7:0] buf_data;
    logic       load_buf0;
    logic       load_buf1;
    logic       buf_empty0 = 1'b0;
    logic       buf_empty1 = 1'b0;
    logic       tx_done = 1'b0;
    logic       tx_nack = 1'b0;

    int         checks = 0;
    int         failures = 0;
    logic [1:0] done_seen;
    logic [1:0] err_seen;
    logic       start_seen;
    logic       req_seen;
    logic [1:0] strobe_seen;

    i2c_tx_arbiter #(.ADDR_W(7), .LEN_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_len0   (req_len0),
        .req_len1   (req_len1),
        .grant      (grant),
        .byte_req   (byte_req),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .done       (done),
        .err        (err),
        .tx_start   (tx_start),
        .tx_addr    (tx_addr),
        .tx_len     (tx_len),
        .buf_data   (buf_data),
        .load_buf0  (load_buf0),
        .load_buf1  (load_buf1),
        .buf_empty0 (buf_empty0),
        .buf_empty1 (buf_empty1),
        .tx_done    (tx_done),
        .tx_nack    (tx_nack)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        done_seen   = done_seen | done;
        err_seen    = err_seen | err;
        start_seen  = start_seen | tx_start;
        req_seen    = req_seen | byte_req;
        strobe_seen = strobe_seen | {load_buf1, load_buf0};
    endtask

    task automatic clear_mon();
        done_seen   = 2'b00;
        err_seen    = 2'b00;
        start_seen  = 1'b0;
        req_seen    = 1'b0;
        strobe_seen = 2'b00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 2'b00;
        byte_valid = 1'b0;
        buf_empty0 = 1'b0;
        buf_empty1 = 1'b0;
        tx_done = 1'b0;
        tx_nack = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_grant(input logic [1:0] g, input string tag);
        int n = 0;
        while (grant == 2'b00 && n < 20) begin
            tick();
            n++;
        end
        check_val(tag, 32'(grant), 32'(g));
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!tx_start && n < 20) begin
            tick();
            n++;
        end
        check_val(tag, 32'(tx_start), 32'h1);
    endtask

    // Waits for byte_req, supplies a byte after dly cycles, checks the resulting strobe.
    task automatic serve(input logic [7:0] b, input int dly, input logic k, input string tag);
        int n = 0;
        while (!byte_req && n < 20) begin
            tick();
            n++;
        end
        check_val({tag, "_req"}, 32'(byte_req), 32'h1);
        repeat (dly) tick();
        byte_in = b;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
        check_val({tag, "_ld"}, 32'({load_buf1, load_buf0}), k ? 32'h2 : 32'h1);
        check_val({tag, "_data"}, 32'(buf_data), 32'(b));
    endtask

    task automatic finish_done(input logic [1:0] g, input string tag);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check_val(tag, 32'(done), 32'(g));
    endtask

    initial begin
        clear_mon();
        do_reset();
        check_val("reset_outputs", 32'({grant, byte_req, done, err, tx_start, tx_addr, tx_len,
                                       buf_data, load_buf0, load_buf1}), 32'h0);

        // Client 0 alone, three bytes, one refill, one ignored drain
        req_addr0 = 7'h50;
        req_len0 = 6'd3;
        req = 2'b01;
        wait_grant(2'b01, "t1_grant");
        check_val("t1_addr", 32'(tx_addr), 32'h50);
        check_val("t1_len", 32'(tx_len), 32'd3);
        req = 2'b00;
        serve(8'hA1, 0, 1'b0, "t1_a");
        serve(8'hB2, 0, 1'b1, "t1_b");
        check_val("t1_start_low", 32'(tx_start), 32'h0);
        tick();
        check_val("t1_start_rise", 32'(tx_start), 32'h1);
        buf_empty0 = 1'b1;
        tick();
        buf_empty0 = 1'b0;
        check_val("t1_refill_req", 32'(byte_req), 32'h1);
        serve(8'hC3, 0, 1'b0, "t1_c");
        clear_mon();
        buf_empty1 = 1'b1;
        tick();
        buf_empty1 = 1'b0;
        tick();
        tick();
        check_val("t1_extra_ignored", 32'({req_seen, strobe_seen}), 32'h0);
        finish_done(2'b01, "t1_done");
        check_val("t1_clear", 32'({grant, tx_start}), 32'h0);
        tick();
        check_val("t1_done_pulse", 32'(done), 32'h0);

        // Both clients continuously, len 2: 01, 10, 01
        do_reset();
        req_addr0 = 7'h50;
        req_addr1 = 7'h2A;
        req_len0 = 6'd2;
        req_len1 = 6'd2;
        req = 2'b11;
        for (int i = 0; i < 3; i++) begin
            logic [1:0] g;
            g = (i == 1) ? 2'b10 : 2'b01;
            wait_grant(g, "t2_grant");
            check_val("t2_addr", 32'(tx_addr), (i == 1) ? 32'h2A : 32'h50);
            serve(8'(8'h10 + i), 0, 1'b0, "t2_a");
            serve(8'(8'h20 + i), 0, 1'b1, "t2_b");
            wait_start("t2_start");
            if (i == 2) begin
                req = 2'b00;
            end
            finish_done(g, "t2_done");
        end
        tick();
        tick();

        // Zero-length burst on client 1
        do_reset();
        clear_mon();
        req_len1 = 6'd0;
        req = 2'b10;
        wait_grant(2'b10, "t3_grant");
        req = 2'b00;
        tick();
        check_val("t3_done", 32'(done), 32'h2);
        check_val("t3_grant_clr", 32'(grant), 32'h0);
        tick();
        tick();
        check_val("t3_no_start", 32'(start_seen), 32'h0);

        // Simultaneous drains with slow byte_valid: buffer 0 refilled first
        req_addr0 = 7'h33;
        req_len0 = 6'd4;
        req = 2'b01;
        wait_grant(2'b01, "t4_grant");
        req = 2'b00;
        serve(8'h41, 3, 1'b0, "t4_a");
        serve(8'h42, 3, 1'b1, "t4_b");
        wait_start("t4_start");
        buf_empty0 = 1'b1;
        buf_empty1 = 1'b1;
        tick();
        buf_empty0 = 1'b0;
        buf_empty1 = 1'b0;
        serve(8'h43, 3, 1'b0, "t4_c");
        serve(8'h44, 3, 1'b1, "t4_d");
        finish_done(2'b01, "t4_done");

        // NACK while a refill fetch is outstanding
        req_addr1 = 7'h2A;
        req_len1 = 6'd3;
        req = 2'b10;
        wait_grant(2'b10, "t5_grant");
        req_addr0 = 7'h50;
        req_len0 = 6'd2;
        req = 2'b01;
        serve(8'h51, 0, 1'b0, "t5_a");
        serve(8'h52, 0, 1'b1, "t5_b");
        wait_start("t5_start");
        buf_empty0 = 1'b1;
        tick();
        buf_empty0 = 1'b0;
        check_val("t5_fetch_req", 32'(byte_req), 32'h1);
        tick();
        tx_nack = 1'b1;
        tick();
        tx_nack = 1'b0;
        check_val("t5_err", 32'(err), 32'h2);
        check_val("t5_no_done", 32'(done), 32'h0);
        check_val("t5_clear", 32'({grant, tx_start}), 32'h0);
        clear_mon();
        byte_in = 8'hEE;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
        tick();
        check_val("t5_late_dropped", 32'(strobe_seen), 32'h0);
        wait_grant(2'b01, "t5_next_grant");
        check_val("t5_next_addr", 32'(tx_addr), 32'h50);
        req = 2'b00;
        serve(8'h61, 0, 1'b0, "t5_c");
        serve(8'h62, 0, 1'b1, "t5_d");
        wait_start("t5_start2");
        finish_done(2'b01, "t5_done");

        // Reset mid-RUN after client 0 was last granted
        req = 2'b01;
        wait_grant(2'b01, "t6_grant");
        req = 2'b00;
        serve(8'h71, 0, 1'b0, "t6_a");
        serve(8'h72, 0, 1'b1, "t6_b");
        wait_start("t6_start");
        clear_mon();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t6_async_clear", 32'({grant, byte_req, done, err, tx_start, tx_addr, tx_len,
                                        buf_data, load_buf0, load_buf1}), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        req = 2'b11;
        wait_grant(2'b01, "t6_prio_after_reset");
        req = 2'b00;
        check_val("t6_no_done_err", 32'({done_seen, err_seen}), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
